wei_fetch_sched: RTL and testbench

Round-robin scheduler that shares the single weight-SRAM read port among `NUM_PEC` PE clusters. Each PEC pulses a get-weight request. The block queues the request, grants PECs one at a time in rotating order, and issues a `BURST_LEN`-word read burst for the granted PEC. It forwards the returned words on a broadcast bus with a one-hot per-PEC valid. It sits between the PEC array and the weight buffer and replaces the fixed one-hot shift sequencing of weight readiness.

---
 rtl/wei_sched_pkg.sv | 8 +
 rtl/wei_fetch_sched_rr_arbiter.sv | 21 ++
 rtl/wei_fetch_sched.sv | 132 +++++++++++++
 tb/tb_wei_fetch_sched.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/wei_sched_pkg.sv
// wei_sched_pkg: shared types and default sizes for the weight fetch scheduler
package wei_sched_pkg;
    typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;
    localparam int WS_NUM_PEC   = 16;
    localparam int WS_BURST_LEN = 8;
    localparam int CNT_W        = $clog2(WS_BURST_LEN);
    localparam int IDX_W        = $clog2(WS_NUM_PEC);
endpackage

// File: rtl/wei_fetch_sched_rr_arbiter.sv
// rr_arbiter: combinational round-robin picker, first request after last_grant wins
module rr_arbiter
    import wei_sched_pkg::*;
#(
    parameter int N  = WS_NUM_PEC,
    parameter int IW = IDX_W
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_vld
);
    // scan from lowest to highest priority so the nearest requester after last_grant overwrites
    always_comb begin
        gnt_idx = '0;
        for (int k = N; k >= 1; k--) begin
            if (req[(int'(last_grant) + k) % N]) gnt_idx = IW'((int'(last_grant) + k) % N);
        end
    end
    assign gnt_vld = |req;
endmodule

// File: rtl/wei_fetch_sched.sv
// wei_fetch_sched: round-robin weight-SRAM burst scheduler for the PE clusters
module wei_fetch_sched
    import wei_sched_pkg::*;
#(
    parameter int NUM_PEC   = WS_NUM_PEC,
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 64,
    parameter int BURST_LEN = WS_BURST_LEN,
    parameter int RD_LAT    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [ADDR_W-1:0]  cfg_base_addr,
    input  logic [NUM_PEC-1:0] pec_get_wei,
    output logic               sram_rd_en,
    output logic [ADDR_W-1:0]  sram_rd_addr,
    input  logic [DATA_W-1:0]  sram_rd_data,
    output logic [DATA_W-1:0]  wei_data,
    output logic [NUM_PEC-1:0] pec_wei_vld,
    output logic               wei_last,
    output logic [NUM_PEC-1:0] pending,
    output logic               busy
);
    localparam int IW = $clog2(NUM_PEC);
    localparam int CW = $clog2(BURST_LEN);

    state_t                       state_q;
    logic [IW-1:0]                grant_q, last_grant_q, arb_idx;
    logic [CW-1:0]                cnt_q;
    logic                         rd_en_q, busy_q, arb_vld, last_rd;
    logic [NUM_PEC-1:0]           pending_q, pending_d;
    logic [RD_LAT-1:0]            vld_pipe_q, last_pipe_q;
    logic [RD_LAT-1:0][IW-1:0]    idx_pipe_q;
    logic [DATA_W-1:0]            wei_data_q;
    logic [NUM_PEC-1:0]           pec_wei_vld_q;
    logic                         wei_last_q;

    rr_arbiter #(.N(NUM_PEC), .IW(IW)) u_arb (
        .req        (pending_q),
        .last_grant (last_grant_q),
        .gnt_idx    (arb_idx),
        .gnt_vld    (arb_vld)
    );

    assign last_rd = (state_q == READ) && (cnt_q == CW'(BURST_LEN - 1));

    // a new request on the same edge as the final read of that PEC keeps the bit set
    always_comb begin
        pending_d = (pending_q & ~(last_rd ? (NUM_PEC'(1) << grant_q) : '0)) | pec_get_wei;
    end

    // pending request register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pending_q <= '0;
        else        pending_q <= pending_d;
    end

    // grant / burst / drain sequencing with registered strobe and busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            grant_q      <= '0;
            last_grant_q <= IW'(NUM_PEC - 1);
            cnt_q        <= '0;
            rd_en_q      <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (en && arb_vld) begin
                    grant_q      <= arb_idx;
                    last_grant_q <= arb_idx;
                    cnt_q        <= '0;
                    rd_en_q      <= 1'b1;
                    busy_q       <= 1'b1;
                    state_q      <= READ;
                end
                READ: begin
                    cnt_q <= cnt_q + CW'(1);
                    if (last_rd) begin
                        rd_en_q <= 1'b0;
                        state_q <= DRAIN;
                    end
                end
                DRAIN: if (wei_last_q) begin
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // carry valid/last/grant alongside the SRAM read latency
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe_q  <= '0;
            last_pipe_q <= '0;
            idx_pipe_q  <= '0;
        end else begin
            vld_pipe_q[0]  <= rd_en_q;
            last_pipe_q[0] <= last_rd;
            idx_pipe_q[0]  <= grant_q;
            for (int k = 1; k < RD_LAT; k++) begin
                vld_pipe_q[k]  <= vld_pipe_q[k-1];
                last_pipe_q[k] <= last_pipe_q[k-1];
                idx_pipe_q[k]  <= idx_pipe_q[k-1];
            end
        end
    end

    // register returned words onto the broadcast bus with a one-hot valid
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wei_data_q    <= '0;
            pec_wei_vld_q <= '0;
            wei_last_q    <= 1'b0;
        end else begin
            if (vld_pipe_q[RD_LAT-1]) wei_data_q <= sram_rd_data;
            pec_wei_vld_q <= vld_pipe_q[RD_LAT-1] ? (NUM_PEC'(1) << idx_pipe_q[RD_LAT-1]) : '0;
            wei_last_q    <= vld_pipe_q[RD_LAT-1] && last_pipe_q[RD_LAT-1];
        end
    end

    assign sram_rd_en   = rd_en_q;
    assign sram_rd_addr = rd_en_q ? cfg_base_addr + ADDR_W'({grant_q, cnt_q}) : '0;
    assign wei_data     = wei_data_q;
    assign pec_wei_vld  = pec_wei_vld_q;
    assign wei_last     = wei_last_q;
    assign pending      = pending_q;
    assign busy         = busy_q;
endmodule

// File: tb/tb_wei_fetch_sched.sv
// tb_wei_fetch_sched: randomized and directed checks against a burst-level schedule model
module tb_wei_fetch_sched;
    localparam int N  = 16;
    localparam int AW = 12;
    localparam int DW = 64;
    localparam int BL = 8;
    localparam int RL = 1;

    logic          clk = 1'b0, rst_n = 1'b0, en = 1'b0;
    logic [AW-1:0] base = '0;
    logic [N-1:0]  pec_get_wei = '0;
    logic          sram_rd_en, wei_last, busy;
    logic [AW-1:0] sram_rd_addr;
    logic [DW-1:0] sram_rd_data, wei_data;
    logic [N-1:0]  pec_wei_vld, pending;
    logic [DW-1:0] sp [RL];

    int n_chk = 0, n_err = 0;
    int c = 0, m_s = 0, m_p = 0, m_last = N - 1;
    bit have = 0;
    logic [N-1:0] m_pend = '0, prev_vld = '0;
    int dut_log[$];
    int n_vld = 0, n_rd = 0;

    always #5 clk = ~clk;

    wei_fetch_sched #(.NUM_PEC(N), .ADDR_W(AW), .DATA_W(DW), .BURST_LEN(BL), .RD_LAT(RL)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .cfg_base_addr (base),
        .pec_get_wei   (pec_get_wei),
        .sram_rd_en    (sram_rd_en),
        .sram_rd_addr  (sram_rd_addr),
        .sram_rd_data  (sram_rd_data),
        .wei_data      (wei_data),
        .pec_wei_vld   (pec_wei_vld),
        .wei_last      (wei_last),
        .pending       (pending),
        .busy          (busy)
    );

    function automatic logic [DW-1:0] wdata(input logic [AW-1:0] a);
        return {2{~a, a, 8'hA5}};
    endfunction

    // SRAM with fixed read latency; junk on the bus when not reading
    always @(posedge clk) begin
        sp[0] <= sram_rd_en ? wdata(sram_rd_addr) : {$urandom, $urandom};
        for (int i = 1; i < RL; i++) sp[i] <= sp[i-1];
    end
    assign sram_rd_data = sp[RL-1];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [AW-1:0] waddr(input int off);
        return AW'(int'(base) + m_p * BL + off);
    endfunction

    function automatic bit m_busy();
        return have && c <= m_s + RL + BL;
    endfunction

    task automatic model_reset();
        have = 0;
        m_pend = '0;
        m_last = N - 1;
        prev_vld = '0;
    endtask

    task automatic cycle(input logic [N-1:0] req, input logic en_v);
        int k;
        logic [N-1:0] ev, clr;
        logic erd, el, eb;
        @(negedge clk);
        erd = have && c >= m_s && c < m_s + BL;
        k = c - m_s - RL - 1;
        ev = (have && k >= 0 && k < BL) ? (N'(1) << m_p) : '0;
        el = (ev != 0) && k == BL - 1;
        eb = have && c >= m_s && c <= m_s + RL + BL;
        chk("rd_en", 64'(sram_rd_en), 64'(erd));
        if (erd) chk("rd_addr", 64'(sram_rd_addr), 64'(waddr(c - m_s)));
        chk("vld", 64'(pec_wei_vld), 64'(ev));
        if (ev != 0) chk("data", wei_data, wdata(waddr(k)));
        chk("last", 64'(wei_last), 64'(el));
        chk("pending", 64'(pending), 64'(m_pend));
        chk("busy", 64'(busy), 64'(eb));
        if (pec_wei_vld != 0) begin
            n_vld++;
            if (prev_vld == 0)
                for (int i = 0; i < N; i++) if (pec_wei_vld[i]) dut_log.push_back(i);
        end
        prev_vld = pec_wei_vld;
        if (sram_rd_en) n_rd++;
        pec_get_wei = req;
        en = en_v;
        clr = '0;
        if (have && c == m_s + BL - 1) clr[m_p] = 1'b1;
        if (!m_busy() && en_v && m_pend != 0) begin
            for (int i = 1; i <= N; i++) begin
                if (m_pend[(m_last + i) % N]) begin
                    m_p = (m_last + i) % N;
                    break;
                end
            end
            m_last = m_p;
            m_s = c + 1;
            have = 1;
        end
        m_pend = (m_pend & ~clr) | req;
        c++;
    endtask

    task automatic do_reset();
        #2 rst_n = 1'b0;
        pec_get_wei = '0;
        #1;
        chk("rst_rd_en", 64'(sram_rd_en), 64'(0));
        chk("rst_addr", 64'(sram_rd_addr), 64'(0));
        chk("rst_data", wei_data, 64'(0));
        chk("rst_vld", 64'(pec_wei_vld), 64'(0));
        chk("rst_last", 64'(wei_last), 64'(0));
        chk("rst_pending", 64'(pending), 64'(0));
        chk("rst_busy", 64'(busy), 64'(0));
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 300 && (m_busy() || m_pend != 0); i++) cycle('0, 1'b1);
        cycle('0, 1'b1);
        chk("idle_busy", 64'(busy), 64'(0));
        chk("idle_pending", 64'(pending), 64'(0));
    endtask

    initial begin
        int s1;
        int exp2[6] = '{0, 5, 15, 0, 5, 15};
        do_reset();
        base = 12'h100;
        n_vld = 0;
        n_rd = 0;
        cycle(N'(1) << 3, 1'b1);
        wait_idle();
        chk("t1_nvld", 64'(n_vld), 64'(8));
        chk("t1_nrd", 64'(n_rd), 64'(8));

        do_reset();
        dut_log.delete();
        cycle(N'(1) | (N'(1) << 5) | (N'(1) << 15), 1'b1);
        wait_idle();
        cycle(N'(1) | (N'(1) << 5) | (N'(1) << 15), 1'b1);
        wait_idle();
        chk("t2_nbursts", 64'(dut_log.size()), 64'(6));
        for (int i = 0; i < 6 && i < dut_log.size(); i++) chk("t2_order", 64'(dut_log[i]), 64'(exp2[i]));

        dut_log.delete();
        cycle(N'(1) << 2, 1'b1);
        cycle('0, 1'b1);
        s1 = m_s;
        for (int i = 0; i < 40; i++) cycle((c == s1 + 3 || c == s1 + BL - 1) ? (N'(1) << 2) : '0, 1'b1);
        wait_idle();
        chk("t3_bursts", 64'(dut_log.size()), 64'(2));

        dut_log.delete();
        cycle((N'(1) << 4) | (N'(1) << 7), 1'b1);
        cycle('0, 1'b1);
        s1 = m_s;
        while (c < s1 + 2) cycle('0, 1'b1);
        n_vld = 0;
        n_rd = 0;
        repeat (30) cycle('0, 1'b0);
        chk("t4_nvld", 64'(n_vld), 64'(8));
        chk("t4_nrd", 64'(n_rd), 64'(6));
        chk("t4_pending_held", 64'(pending), 64'(N'(1) << 7));
        wait_idle();
        chk("t4_nbursts", 64'(dut_log.size()), 64'(2));
        if (dut_log.size() == 2) begin
            chk("t4_first", 64'(dut_log[0]), 64'(4));
            chk("t4_second", 64'(dut_log[1]), 64'(7));
        end

        base = 12'hFF8;
        cycle(N'(1) << 1, 1'b1);
        cycle('0, 1'b1);
        cycle('0, 1'b1);
        chk("t5_addr0", 64'(sram_rd_addr), 64'(0));
        wait_idle();

        base = 12'h040;
        cycle(N'(1) << 6, 1'b1);
        cycle('0, 1'b1);
        s1 = m_s;
        while (c <= s1 + BL) cycle((c == s1 + 1) ? (N'(1) << 9) : '0, 1'b1);
        do_reset();
        n_vld = 0;
        repeat (15) cycle('0, 1'b1);
        chk("t6_no_vld", 64'(n_vld), 64'(0));

        for (int i = 0; i < 800; i++) begin
            logic [N-1:0] r;
            r = ($urandom_range(0, 5) == 0) ? N'($urandom & $urandom & $urandom) : '0;
            if (!m_busy() && $urandom_range(0, 9) == 0) base = AW'($urandom);
            cycle(r, $urandom_range(0, 9) != 0);
        end
        wait_idle();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
